// File: rtl/traffic_signal_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_signal_ctrl
//
// Highway / country-road junction controller. Six-state Moore FSM with a
// single down-counter that times every phase. The highway rests on green and
// yields only once its minimum green has elapsed and a country car is present.
// Each yellow is followed by an all-red clearance phase. Country green is held
// for at least MIN_CG cycles and at most MAX_CG cycles.
//
// Ports:
//   clk    in   1  clock, all state changes on the rising edge
//   clear  in   1  asynchronous active-high reset (forces HG immediately)
//   X      in   1  country-road car present, sampled on the rising edge
//   hwg    out  2  highway lamp   (RED=0, YELLOW=1, GREEN=2)
//   cntry  out  2  country lamp   (same encoding)
//   state  out  3  current state code (HG=0 HY=1 AR1=2 CG=3 CY=4 AR2=5)
// ----------------------------------------------------------------------------
module traffic_signal_ctrl #(
    parameter int Y2R     = 3,
    parameter int R2G     = 2,
    parameter int MIN_HWG = 8,
    parameter int MIN_CG  = 4,
    parameter int MAX_CG  = 10,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       X,
    output logic [1:0] hwg,
    output logic [1:0] cntry,
    output logic [2:0] state
);

    localparam logic [2:0] S_HG  = 3'd0;
    localparam logic [2:0] S_HY  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_CG  = 3'd3;
    localparam logic [2:0] S_CY  = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    // Timer load values are duration-1 so a phase of D lasts exactly D cycles.
    localparam logic [TW-1:0] LD_HWG = TW'(MIN_HWG - 1);
    localparam logic [TW-1:0] LD_Y2R = TW'(Y2R - 1);
    localparam logic [TW-1:0] LD_R2G = TW'(R2G - 1);
    localparam logic [TW-1:0] LD_MCG = TW'(MAX_CG - 1);

    // One extra bit so MAX_CG = 2^TW still fits in the elapsed arithmetic.
    localparam logic [TW:0] MAX_CG_W = (TW+1)'(MAX_CG);
    localparam logic [TW:0] MIN_CG_W = (TW+1)'(MIN_CG);

    logic [2:0]    state_reg, state_next;
    logic [TW-1:0] tmr_reg, tmr_next;
    logic [TW:0]   elapsed;
    logic          tmr_zero;

    function automatic logic [TW-1:0] load_val(input logic [2:0] s);
        case (s)
            S_HY, S_CY:   load_val = LD_Y2R;
            S_AR1, S_AR2: load_val = LD_R2G;
            S_CG:         load_val = LD_MCG;
            default:      load_val = LD_HWG;
        endcase
    endfunction

    assign tmr_zero = (tmr_reg == '0);
    // Counts country-green cycles: 1 in the first CG cycle.
    assign elapsed  = MAX_CG_W - {1'b0, tmr_reg};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HG:  if (tmr_zero && X) state_next = S_HY;
            S_HY:  if (tmr_zero)      state_next = S_AR1;
            S_AR1: if (tmr_zero)      state_next = S_CG;
            // Leave on max-green expiry, or early once the road empties
            // after the minimum green has been served.
            S_CG:  if (tmr_zero || (!X && elapsed >= MIN_CG_W)) state_next = S_CY;
            S_CY:  if (tmr_zero)      state_next = S_AR2;
            S_AR2: if (tmr_zero)      state_next = S_HG;
            default:                  state_next = S_HG;   // recover from codes 6/7
        endcase
    end

    always_comb begin
        tmr_next = tmr_reg;
        if (state_next != state_reg) begin
            tmr_next = load_val(state_next);
        end else if (!tmr_zero) begin
            tmr_next = tmr_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg <= S_HG;
            tmr_reg   <= LD_HWG;
        end else begin
            state_reg <= state_next;
            tmr_reg   <= tmr_next;
        end
    end

    always_comb begin
        hwg   = LAMP_RED;
        cntry = LAMP_RED;
        case (state_reg)
            S_HG: hwg   = LAMP_GREEN;
            S_HY: hwg   = LAMP_YELLOW;
            S_CG: cntry = LAMP_GREEN;
            S_CY: cntry = LAMP_YELLOW;
            default: ;
        endcase
    end

    assign state = state_reg;

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// ----------------------------------------------------------------------------
// tb_traffic_signal_ctrl
//
// Directed bench for traffic_signal_ctrl at default parameters. Inputs change
// 1 ns after a rising edge; outputs are checked there too, well away from the
// next edge. Each run_phase call checks the state/lamps for the current cycle
// and then advances one clock, n times.
// ----------------------------------------------------------------------------
module tb_traffic_signal_ctrl;

    localparam logic [2:0] HG  = 3'd0;
    localparam logic [2:0] HY  = 3'd1;
    localparam logic [2:0] AR1 = 3'd2;
    localparam logic [2:0] CG  = 3'd3;
    localparam logic [2:0] CY  = 3'd4;
    localparam logic [2:0] AR2 = 3'd5;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       X = 1'b0;
    logic [1:0] hwg;
    logic [1:0] cntry;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    traffic_signal_ctrl dut (
        .clk   (clk),
        .clear (clear),
        .X     (X),
        .hwg   (hwg),
        .cntry (cntry),
        .state (state)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_hwg(input logic [2:0] s);
        case (s)
            HG:      return 2'd2;
            HY:      return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_cntry(input logic [2:0] s);
        case (s)
            CG:      return 2'd2;
            CY:      return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] s);
        check({tag, ".state"}, int'(state), int'(s));
        check({tag, ".hwg"},   int'(hwg),   int'(exp_hwg(s)));
        check({tag, ".cntry"}, int'(cntry), int'(exp_cntry(s)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_phase(input string tag, input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            check_all($sformatf("%s[%0d]", tag, i + 1), s);
            step();
        end
    endtask

    // Assert clear across one edge, check the reset outputs, release 1 ns
    // after that edge with X set to x_val.
    task automatic do_clear(input string tag, input logic x_val);
        clear = 1'b1;
        X = x_val;
        #1;
        check_all({tag, ".in_clear"}, HG);
        step();
        check_all({tag, ".in_clear_edge"}, HG);
        clear = 1'b0;
    endtask

    initial begin
        // Reset state and X held low for 100 cycles: highway stays green.
        do_clear("rst", 1'b0);
        run_phase("x0_hold", HG, 100);

        // X held high: full cycle then a second HG of 8 before yellow.
        do_clear("x1", 1'b1);
        run_phase("x1.HG",  HG,  8);
        run_phase("x1.HY",  HY,  3);
        run_phase("x1.AR1", AR1, 2);
        run_phase("x1.CG",  CG,  10);
        run_phase("x1.CY",  CY,  3);
        run_phase("x1.AR2", AR2, 2);
        run_phase("x1.HG2", HG,  8);
        run_phase("x1.HY2", HY,  1);

        // X high only in HG cycles 1-7: the minimum green is never met with X.
        do_clear("early", 1'b1);
        run_phase("early.HG", HG, 7);
        X = 1'b0;
        run_phase("early.hold", HG, 20);

        // Continue: X high at an eligible HG cycle, then low from CG cycle 1
        // -> CG is exactly the minimum of 4 cycles.
        X = 1'b1;
        run_phase("min.HG",  HG,  1);
        run_phase("min.HY",  HY,  3);
        run_phase("min.AR1", AR1, 2);
        X = 1'b0;
        run_phase("min.CG",  CG,  4);
        run_phase("min.CY",  CY,  3);
        run_phase("min.AR2", AR2, 2);
        run_phase("min.HG",  HG,  10);

        // X high through CG cycle 6, low from cycle 7 -> CG lasts 7 cycles.
        do_clear("mid", 1'b1);
        run_phase("mid.HG",  HG,  8);
        run_phase("mid.HY",  HY,  3);
        run_phase("mid.AR1", AR1, 2);
        run_phase("mid.CG",  CG,  6);
        X = 1'b0;
        run_phase("mid.CG7", CG,  1);
        run_phase("mid.CY",  CY,  3);
        run_phase("mid.AR2", AR2, 2);
        run_phase("mid.HG2", HG,  3);

        // 2 ns clear pulse in the middle of CG, between edges.
        do_clear("async", 1'b1);
        run_phase("async.HG",  HG,  8);
        run_phase("async.HY",  HY,  3);
        run_phase("async.AR1", AR1, 2);
        run_phase("async.CG",  CG,  3);
        check_all("async.before_pulse", CG);
        #2;
        clear = 1'b1;
        #1;
        check_all("async.during_pulse", HG);
        #1;
        clear = 1'b0;
        #1;
        check_all("async.after_pulse", HG);
        run_phase("async.HG_again", HG, 8);
        run_phase("async.HY_again", HY, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
